delta_sigma_decimator: RTL



---
 rtl/delta_sigma_decimator_pkg.sv | 12 +
 rtl/delta_sigma_decimator_cic_comb.sv | 32 +++
 rtl/delta_sigma_decimator.sv | 90 +++++++++
 3 files changed

// File: rtl/delta_sigma_decimator_pkg.sv
// Shared constants and helpers for the CIC delta-sigma decimator.
package delta_sigma_decimator_pkg;

  // PCM resolution shared with the sound path and the modulator.
  localparam int RESOLUTION = 14;

  // CIC register width: input width plus log2(R^N) bits of growth.
  function automatic int cic_width(input int inbits, input int order, input int decim_log2);
    return inbits + order * decim_log2;
  endfunction

endpackage

// File: rtl/delta_sigma_decimator_cic_comb.sv
// One CIC comb (differentiator) stage; only advances on a valid input.
module delta_sigma_decimator_cic_comb
  import delta_sigma_decimator_pkg::*;
#(
  parameter int W = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] prev,
  input  logic         prev_vld,
  output logic [W-1:0] diff,
  output logic         diff_vld
);

  logic [W-1:0] dly;

  // diff = current decimated sample minus previous one, modulo 2^W
  always_ff @(posedge clk) begin
    if (rst) begin
      dly      <= '0;
      diff     <= '0;
      diff_vld <= 1'b0;
    end else begin
      diff_vld <= prev_vld;
      if (prev_vld) begin
        dly  <= prev;
        diff <= prev - dly;
      end
    end
  end

endmodule

// File: rtl/delta_sigma_decimator.sv
// CIC decimator: ORDER integrators at clk rate, decimate by 2^DECIM_LOG2,
// ORDER combs at the decimated rate, top OUTBITS of the result as PCM.
module delta_sigma_decimator
  import delta_sigma_decimator_pkg::*;
#(
  parameter int INBITS     = 4,
  parameter int OUTBITS    = RESOLUTION,
  parameter int ORDER      = 3,
  parameter int DECIM_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INBITS-1:0]  audio_i,
  output logic [OUTBITS-1:0] sample_o,
  output logic               valid_o
);

  localparam int W = cic_width(INBITS, ORDER, DECIM_LOG2);

  logic [ORDER-1:0][W-1:0] integ;
  logic [DECIM_LOG2-1:0]   cnt;
  logic                    tick;
  logic [W-1:0]            x0;
  logic                    v0;
  logic [ORDER:0][W-1:0]   x;
  logic [ORDER:0]          vld_pipe;
  logic [OUTBITS-1:0]      samp_nxt;

  // tick on the last cycle of each decimation period
  assign tick = &cnt;

  // integrator cascade; wrap-around is harmless, the combs undo it exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      integ <= '0;
    end else begin
      integ[0] <= integ[0] + W'(audio_i);
      for (int k = 1; k < ORDER; k++)
        integ[k] <= integ[k] + integ[k-1];
    end
  end

  // decimation counter and capture of the last integrator on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      x0  <= '0;
      v0  <= 1'b0;
    end else begin
      cnt <= cnt + DECIM_LOG2'(1);
      v0  <= tick;
      if (tick)
        x0 <= integ[ORDER-1];
    end
  end

  assign x[0]        = x0;
  assign vld_pipe[0] = v0;

  for (genvar k = 1; k <= ORDER; k++) begin : g_comb
    delta_sigma_decimator_cic_comb #(.W(W)) u_comb (
      .clk      (clk),
      .rst      (rst),
      .prev     (x[k-1]),
      .prev_vld (vld_pipe[k-1]),
      .diff     (x[k]),
      .diff_vld (vld_pipe[k])
    );
  end

  // take the top OUTBITS; pad LSBs with zeros if the CIC is narrower
  if (OUTBITS <= W) begin : g_trunc
    assign samp_nxt = x[ORDER][W-1 -: OUTBITS];
  end else begin : g_pad
    assign samp_nxt = {x[ORDER], {(OUTBITS-W){1'b0}}};
  end

  // register the PCM sample and its one-cycle strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= vld_pipe[ORDER];
      if (vld_pipe[ORDER])
        sample_o <= samp_nxt;
    end
  end

endmodule
